// File: rtl/top_level.sv
// top_level: single-cycle 9-bit accumulator processor (ROM, RF, data memory).
// Ports: Clk, Reset (async, active high), Start (hold/restart), Ack (halted).

module instr_rom #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [8:0]    load_data,
   input  logic [AW-1:0] addr,
   output logic [8:0]    data
);
   logic [8:0] inst_rom [DEPTH];

   // Load port exists for in-system programming; images are normally preloaded.
   always_ff @(posedge clk)
      if (load_en) inst_rom[load_addr] <= load_data;

   assign data = inst_rom[addr];
endmodule

module data_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);
   logic [7:0] Core [DEPTH];

   always_ff @(posedge clk)
      if (we) Core[addr] <= wdata;

   assign rdata = Core[addr];
endmodule

module reg_file #(
   parameter int NREGS = 16,
   parameter int RW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [RW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [RW-1:0] raddr,
   output logic [7:0]    rdata,
   output logic [7:0]    acc
);
   logic [7:0] Registers [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) Registers[i] <= '0;
      end else if (we) begin
         Registers[waddr] <= wdata;
      end
   end

   assign rdata = Registers[raddr];
   assign acc   = Registers[0];
endmodule

module top_level #(
   parameter int IROM_DEPTH = 1024,
   parameter int DM_DEPTH   = 256,
   parameter int NREGS      = 16
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Start,
   output logic Ack
);
   localparam int PW  = $clog2(IROM_DEPTH);
   localparam int DAW = $clog2(DM_DEPTH);
   localparam int RW  = $clog2(NREGS);

   typedef enum logic [3:0] {
      OP_LI, OP_LUI, OP_PUT, OP_GET, OP_ADD, OP_SUB, OP_AND, OP_XOR,
      OP_SH, OP_LD, OP_ST, OP_PAR, OP_BZ, OP_BNZ, OP_JMP, OP_SYS
   } op_e;

   localparam logic [6:0] taps [9] = '{
      7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
   };

   // Branch targets for the stored program; entry 1 is the loop head.
   localparam logic [PW-1:0] lut [32] = '{1: PW'(3), default: '0};

   logic [PW-1:0] pc_q, pc_d, pc_inc;
   logic          halted_q, halted_d;
   logic          ack_q, ack_d;
   logic          start_q;
   logic [8:0]    inst;
   op_e           op;
   logic [4:0]    a;
   logic [RW-1:0] r;
   logic [3:0]    tap_idx;
   logic          rf_we;
   logic [RW-1:0] rf_waddr;
   logic [7:0]    rf_wdata, rd, acc;
   logic          dm_we;
   logic [7:0]    dm_rdata;

   instr_rom #(.DEPTH(IROM_DEPTH)) IR1 (
      .clk(Clk), .load_en(1'b0), .load_addr('0), .load_data('0),
      .addr(pc_q), .data(inst)
   );

   reg_file #(.NREGS(NREGS)) RF1 (
      .clk(Clk), .rst(Reset), .we(rf_we), .waddr(rf_waddr),
      .wdata(rf_wdata), .raddr(r), .rdata(rd), .acc(acc)
   );

   data_mem #(.DEPTH(DM_DEPTH)) DM1 (
      .clk(Clk), .we(dm_we), .addr(DAW'(rd)), .wdata(acc),
      .rdata(dm_rdata)
   );

   always_comb begin
      op      = op_e'(inst[8:5]);
      a       = inst[4:0];
      r       = RW'(inst[3:0]);
      tap_idx = (a <= 5'd8) ? a[3:0] : 4'd0;
      pc_inc  = (pc_q == PW'(IROM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
   end

   always_comb begin
      pc_d     = pc_q;
      halted_d = halted_q;
      ack_d    = ack_q;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = acc;
      dm_we    = 1'b0;
      if (Start) begin
         // A fresh Start pulse re-arms a halted program in place.
         if (!start_q) begin
            halted_d = 1'b0;
            ack_d    = 1'b0;
         end
      end else if (!halted_q) begin
         pc_d  = pc_inc;
         rf_we = 1'b1;
         unique case (op)
            OP_LI:  rf_wdata = {3'b0, a};
            OP_LUI: rf_wdata = {a[2:0], acc[4:0]};
            OP_PUT: rf_waddr = r;
            OP_GET: rf_wdata = rd;
            OP_ADD: rf_wdata = acc + rd;
            OP_SUB: rf_wdata = acc - rd;
            OP_AND: rf_wdata = acc & rd;
            OP_XOR: rf_wdata = acc ^ rd;
            OP_SH:  rf_wdata = a[4] ? (acc >> a[2:0]) : (acc << a[2:0]);
            OP_LD:  rf_wdata = dm_rdata;
            OP_ST: begin
               rf_we = 1'b0;
               dm_we = 1'b1;
            end
            OP_PAR: rf_wdata = {7'b0, ^rd};
            OP_BZ: begin
               rf_we = 1'b0;
               if (acc == 8'd0) pc_d = lut[a];
            end
            OP_BNZ: begin
               rf_we = 1'b0;
               if (acc != 8'd0) pc_d = lut[a];
            end
            OP_JMP: begin
               rf_we = 1'b0;
               pc_d  = lut[a];
            end
            OP_SYS: begin
               if (a <= 5'd8) begin
                  rf_wdata = {1'b0, taps[tap_idx]};
               end else begin
                  rf_we = 1'b0;
                  if (a == 5'd31) begin
                     halted_d = 1'b1;
                     ack_d    = 1'b1;
                     pc_d     = pc_q;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc_q     <= '0;
         halted_q <= 1'b0;
         ack_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
         ack_q    <= ack_d;
         start_q  <= Start;
      end
   end

   assign Ack = ack_q;
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: directed table, hand sequences and random programs vs an ISA model.
// Drives Clk/Reset/Start, preloads ROM and data memory through the hierarchy.

module tb_top_level;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic Start = 1'b1;
   logic Ack;

   int vecs = 0;
   int miscmp = 0;

   top_level dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack));

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string      name;
      logic [8:0] inst;
      int         r0;
      int         r1;
      int         exp;
   } vec_t;

   vec_t tbl[$];

   // Reference model state
   int rom_m [64];
   int core_m [256];
   int reg_m [16];
   int pc_m;
   bit halted_m;
   bit ack_m;
   int taps_m [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

   function automatic logic [8:0] ins(input int op, input int a);
      return 9'((op * 32) + (a % 32));
   endfunction

   function automatic int lut_m(input int a);
      return (a == 1) ? 3 : 0;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         miscmp++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input string nm, input int op, input int a,
                          input int r0, input int r1, input int exp);
      vec_t v;
      v.name = nm;
      v.inst = ins(op, a);
      v.r0   = r0;
      v.r1   = r1;
      v.exp  = exp;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      Start = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic load_rom(input logic [8:0] p[$]);
      for (int i = 0; i < p.size(); i++) dut.IR1.inst_rom[i] = p[i];
   endtask

   task automatic run_to_ack(input int budget, output int cyc);
      @(negedge Clk);
      Start = 1'b0;
      cyc = 0;
      while (Ack !== 1'b1 && cyc < budget) begin
         @(posedge Clk);
         #1;
         cyc++;
      end
   endtask

   task automatic model_step();
      int op, a, r, nxt, x;
      if (halted_m) return;
      op  = rom_m[pc_m] / 32;
      a   = rom_m[pc_m] % 32;
      r   = a % 16;
      nxt = (pc_m + 1) % 1024;
      x   = reg_m[0];
      case (op)
         0:  reg_m[0] = a;
         1:  reg_m[0] = (a % 8) * 32 + x % 32;
         2:  reg_m[r] = x;
         3:  reg_m[0] = reg_m[r];
         4:  reg_m[0] = (x + reg_m[r]) % 256;
         5:  reg_m[0] = (x - reg_m[r] + 256) % 256;
         6:  reg_m[0] = x & reg_m[r];
         7:  reg_m[0] = x ^ reg_m[r];
         8:  reg_m[0] = (a >= 16) ? x / (2 ** (a % 8))
                                   : (x * (2 ** (a % 8))) % 256;
         9:  reg_m[0] = core_m[reg_m[r]];
         10: core_m[reg_m[r]] = x;
         11: reg_m[0] = $countones(reg_m[r]) % 2;
         12: if (x == 0) nxt = lut_m(a);
         13: if (x != 0) nxt = lut_m(a);
         14: nxt = lut_m(a);
         default: begin
            if (a <= 8) reg_m[0] = taps_m[a];
            else if (a == 31) begin
               halted_m = 1'b1;
               ack_m    = 1'b1;
               nxt      = pc_m;
            end
         end
      endcase
      pc_m = nxt;
   endtask

   initial begin
      logic [8:0] p[$];
      int cyc;

      add_vec("add",      4, 1,  'h30, 'h25, 'h55);
      add_vec("add_r0",   4, 0,  'h90, 'h00, 'h20);
      add_vec("sub_wrap", 5, 1,  'h01, 'h02, 'hFF);
      add_vec("and",      6, 1,  'hF0, 'h3C, 'h30);
      add_vec("xor",      7, 1,  'hA5, 'h40, 'hE5);
      add_vec("shr3",     8, 19, 'h60, 'h00, 'h0C);
      add_vec("shr7",     8, 23, 'h80, 'h00, 'h01);
      add_vec("shl3",     8, 3,  'h61, 'h00, 'h08);
      add_vec("par_a5",   11, 1, 'h00, 'hA5, 'h00);
      add_vec("par_a4",   11, 1, 'h00, 'hA4, 'h01);
      add_vec("tap0",     15, 0, 'h00, 'h00, 'h60);
      add_vec("tap4",     15, 4, 'h00, 'h00, 'h6A);
      add_vec("tap8",     15, 8, 'h00, 'h00, 'h7B);
      add_vec("nop9",     15, 9, 'h33, 'h00, 'h33);
      add_vec("get",      3, 1,  'h12, 'h77, 'h77);
      add_vec("lui5",     1, 5,  'hE3, 'h00, 'hA3);
      add_vec("li31",     0, 31, 'h44, 'h00, 'h1F);
      add_vec("bz_nt",    12, 0, 'h01, 'h00, 'h01);
      add_vec("bnz_nt",   13, 0, 'h00, 'h00, 'h00);

      // Reset state
      #1;
      check("rst_ack", Ack, 0);
      do_reset();
      check("rst_r0", dut.RF1.Registers[0], 0);
      check("rst_r15", dut.RF1.Registers[15], 0);

      // Basic program and Ack latency
      p = '{ins(0, 5), ins(2, 3), ins(0, 1), ins(1, 2), ins(15, 31)};
      load_rom(p);
      run_to_ack(20, cyc);
      check("basic_cyc", cyc, 5);
      check("basic_r3", dut.RF1.Registers[3], 'h05);
      check("basic_r0", dut.RF1.Registers[0], 'h41);

      // Single-instruction table
      foreach (tbl[v]) begin
         do_reset();
         p = '{ins(0, tbl[v].r1 % 32), ins(1, tbl[v].r1 / 32), ins(2, 1),
               ins(0, tbl[v].r0 % 32), ins(1, tbl[v].r0 / 32),
               tbl[v].inst, ins(15, 31)};
         load_rom(p);
         run_to_ack(40, cyc);
         check({tbl[v].name, "_cyc"}, cyc, 7);
         check(tbl[v].name, dut.RF1.Registers[0], tbl[v].exp);
      end

      // Memory load/xor/store and parity
      do_reset();
      dut.DM1.Core[64] = 8'hA5;
      dut.DM1.Core[0]  = 8'h00;
      p = '{ins(0, 0), ins(1, 2), ins(2, 1), ins(9, 1), ins(7, 1),
            ins(2, 2), ins(0, 0), ins(2, 3), ins(3, 2), ins(10, 3),
            ins(9, 1), ins(2, 4), ins(11, 4), ins(2, 5), ins(0, 1),
            ins(2, 6), ins(3, 4), ins(5, 6), ins(2, 7), ins(11, 7),
            ins(2, 8), ins(15, 31)};
      load_rom(p);
      run_to_ack(60, cyc);
      check("mem_cyc", cyc, 22);
      check("mem_core0", dut.DM1.Core[0], 'hE5);
      check("mem_core64", dut.DM1.Core[64], 'hA5);
      check("mem_par_a5", dut.RF1.Registers[5], 0);
      check("mem_par_a4", dut.RF1.Registers[8], 1);

      // Branch loop: three passes of a seven-instruction body
      do_reset();
      p = '{ins(0, 1), ins(2, 2), ins(0, 3), ins(5, 2), ins(2, 1),
            ins(3, 5), ins(4, 2), ins(2, 5), ins(3, 1), ins(13, 1),
            ins(15, 31)};
      load_rom(p);
      run_to_ack(100, cyc);
      check("loop_cyc", cyc, 25);
      check("loop_r0", dut.RF1.Registers[0], 0);
      check("loop_cnt", dut.RF1.Registers[5], 3);

      // Mid-program async reset, then rerun from PC 0
      do_reset();
      dut.DM1.Core[100] = 8'h3C;
      @(negedge Clk);
      Start = 1'b0;
      repeat (8) @(posedge Clk);
      @(negedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      check("async_ack", Ack, 0);
      for (int i = 0; i < 16; i++)
         check($sformatf("async_r%0d", i), dut.RF1.Registers[i], 0);
      check("async_core", dut.DM1.Core[100], 'h3C);
      @(negedge Clk);
      Reset = 1'b0;
      Start = 1'b1;
      run_to_ack(100, cyc);
      check("rerun_cyc", cyc, 25);
      check("rerun_cnt", dut.RF1.Registers[5], 3);

      // Start held high: nothing executes
      do_reset();
      dut.DM1.Core[7] = 8'h5A;
      p = '{ins(0, 7), ins(2, 9), ins(10, 9), ins(15, 31)};
      load_rom(p);
      repeat (10) @(posedge Clk);
      #1;
      check("hold_r0", dut.RF1.Registers[0], 0);
      check("hold_r9", dut.RF1.Registers[9], 0);
      check("hold_core", dut.DM1.Core[7], 'h5A);
      check("hold_ack", Ack, 0);
      run_to_ack(20, cyc);
      check("hold_cyc", cyc, 4);
      check("hold_st", dut.DM1.Core[7], 'h07);

      // Start pulse after halt drops Ack; HALT re-executes on release
      @(negedge Clk);
      Start = 1'b1;
      @(posedge Clk);
      #1;
      check("pulse_ack", Ack, 0);
      check("pulse_r9", dut.RF1.Registers[9], 7);
      run_to_ack(10, cyc);
      check("pulse_cyc", cyc, 1);
      @(negedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      check("rst_ack_hi", Ack, 0);
      @(negedge Clk);
      Reset = 1'b0;

      // Random programs vs model
      for (int k = 0; k < 25; k++) begin
         do_reset();
         for (int i = 0; i < 64; i++) begin
            rom_m[i] = $urandom_range(0, 511);
            dut.IR1.inst_rom[i] = 9'(rom_m[i]);
         end
         for (int i = 0; i < 256; i++) begin
            core_m[i] = $urandom_range(0, 255);
            dut.DM1.Core[i] = 8'(core_m[i]);
         end
         for (int i = 0; i < 16; i++) reg_m[i] = 0;
         pc_m = 0;
         halted_m = 1'b0;
         ack_m = 1'b0;
         @(negedge Clk);
         Start = 1'b0;
         for (int c = 0; c < 40; c++) begin
            @(posedge Clk);
            model_step();
         end
         @(negedge Clk);
         check($sformatf("rnd%0d_ack", k), Ack, ack_m);
         for (int i = 0; i < 16; i++)
            check($sformatf("rnd%0d_r%0d", k, i),
                  dut.RF1.Registers[i], reg_m[i]);
         for (int i = 0; i < 256; i++)
            check($sformatf("rnd%0d_m%0d", k, i),
                  dut.DM1.Core[i], core_m[i]);
         Start = 1'b1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end
endmodule
